// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared types and constants for the write-back port arbiter
package ariane_pkg;

  localparam int unsigned XLEN           = 64;
  localparam int unsigned TRANS_ID_BITS  = 3;
  localparam int unsigned WB_ARB_MAX_REQ = 8;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          data;
    exception_t               ex;
  } wb_req_t;

endpackage

// File: rtl/wb_rr_picker.sv
// rtl/wb_rr_picker.sv - combinational one-hot round-robin select
// Grants the first set bit of valid_i searching upward from rr_i, wrapping modulo NR_REQ.
module wb_rr_picker #(
  parameter int unsigned NR_REQ = 3,
  localparam int unsigned PTR_W = $clog2(NR_REQ)
) (
  input  logic [NR_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0]  rr_i,
  output logic [NR_REQ-1:0] grant_o
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < int'(NR_REQ); k++) begin
      sum = {1'b0, rr_i} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NR_REQ)) begin
        sum = sum - (PTR_W+1)'(NR_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares one scoreboard write-back port among NR_REQ buffered units
// Optional conflict counter built when WB_PORT_ARBITER_PERF_EN is defined.
module wb_port_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned NR_REQ = 3,
  parameter int unsigned TID_W  = ariane_pkg::TRANS_ID_BITS,
  parameter int unsigned DATA_W = ariane_pkg::XLEN,
  localparam int unsigned PTR_W = $clog2(NR_REQ)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic [NR_REQ-1:0]                     req_valid_i,
  output logic [NR_REQ-1:0]                     req_ready_o,
  input  logic [NR_REQ*TID_W-1:0]               req_trans_id_i,
  input  logic [NR_REQ*DATA_W-1:0]              req_data_i,
  input  logic [NR_REQ*$bits(exception_t)-1:0]  req_ex_i,
  output logic                                  wb_valid_o,
  input  logic                                  wb_ready_i,
  output logic [TID_W-1:0]                      wb_trans_id_o,
  output logic [DATA_W-1:0]                     wb_data_o,
  output exception_t                            wb_ex_o,
  output logic [31:0]                           conflict_cnt_o
);

  localparam int unsigned EX_W = $bits(exception_t);

  typedef struct packed {
    logic [TID_W-1:0]  trans_id;
    logic [DATA_W-1:0] data;
    exception_t        ex;
  } entry_t;

  logic [NR_REQ-1:0] buf_valid_q, buf_valid_d;
  entry_t            buf_q [NR_REQ];
  entry_t            buf_d [NR_REQ];
  logic [PTR_W-1:0]  rr_q, rr_d;
  logic              lock_q, lock_d;
  logic [NR_REQ-1:0] lock_idx_q, lock_idx_d;
  entry_t            last_q, last_d;

  logic [NR_REQ-1:0] pick_grant;
  logic [NR_REQ-1:0] grant;
  logic [NR_REQ-1:0] pop;
  logic [NR_REQ-1:0] push;
  entry_t            sel;

  wb_rr_picker #(
    .NR_REQ (NR_REQ)
  ) u_picker (
    .valid_i (buf_valid_q),
    .rr_i    (rr_q),
    .grant_o (pick_grant)
  );

  // A stalled grant stays locked so the port sees a stable payload until it is taken.
  always_comb begin
    grant       = lock_q ? lock_idx_q : pick_grant;
    wb_valid_o  = |buf_valid_q;
    pop         = grant & {NR_REQ{wb_valid_o & wb_ready_i}};
    req_ready_o = flush_i ? '1 : (~buf_valid_q | pop);
    push        = req_valid_i & req_ready_o & ~{NR_REQ{flush_i}};
  end

  // Outputs come only from registered buffers; when idle they hold the last granted payload.
  always_comb begin
    sel = '0;
    for (int i = 0; i < int'(NR_REQ); i++) begin
      if (grant[i]) begin
        sel = buf_q[i];
      end
    end
    last_d        = wb_valid_o ? sel : last_q;
    wb_trans_id_o = last_d.trans_id;
    wb_data_o     = last_d.data;
    wb_ex_o       = last_d.ex;
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    for (int i = 0; i < int'(NR_REQ); i++) begin
      buf_d[i]       = buf_q[i];
      buf_valid_d[i] = push[i] | (buf_valid_q[i] & ~pop[i]);
      if (push[i]) begin
        buf_d[i].trans_id = req_trans_id_i[i*TID_W +: TID_W];
        buf_d[i].data     = req_data_i[i*DATA_W +: DATA_W];
        buf_d[i].ex       = req_ex_i[i*EX_W +: EX_W];
      end
    end
    if (flush_i) begin
      buf_valid_d = '0;
    end
  end

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    for (int i = 0; i < int'(NR_REQ); i++) begin
      if (pop[i]) begin
        rr_d = (i == int'(NR_REQ) - 1) ? '0 : PTR_W'(i + 1);
      end
    end
    if (|pop) begin
      lock_d = 1'b0;
    end else if (wb_valid_o && !wb_ready_i) begin
      lock_d     = 1'b1;
      lock_idx_d = grant;
    end
    if (flush_i) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_valid_q <= '0;
      rr_q        <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      last_q      <= '0;
      for (int i = 0; i < int'(NR_REQ); i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      buf_valid_q <= buf_valid_d;
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      last_q      <= last_d;
      for (int i = 0; i < int'(NR_REQ); i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

`ifdef WB_PORT_ARBITER_PERF_EN
  logic [31:0] conflict_q, conflict_d;
  logic [3:0]  n_valid;

  always_comb begin
    n_valid = '0;
    for (int i = 0; i < int'(NR_REQ); i++) begin
      n_valid = n_valid + 4'(buf_valid_q[i]);
    end
    conflict_d = conflict_q;
    if (n_valid >= 4'd2 && conflict_q != 32'hFFFF_FFFF) begin
      conflict_d = conflict_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_cnt_o = conflict_q;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;
  import ariane_pkg::*;

  localparam int NR  = 3;
  localparam int TW  = TRANS_ID_BITS;
  localparam int DW  = XLEN;
  localparam int EXW = $bits(exception_t);
`ifdef WB_PORT_ARBITER_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*TW-1:0]  req_tid;
  logic [NR*DW-1:0]  req_data;
  logic [NR*EXW-1:0] req_ex;
  logic              wb_valid;
  logic              wb_ready;
  logic [TW-1:0]     wb_tid;
  logic [DW-1:0]     wb_data;
  exception_t        wb_ex;
  logic [31:0]       cnt;

  int n_vec;
  int n_err;

  wb_port_arbiter #(
    .NR_REQ (NR),
    .TID_W  (TW),
    .DATA_W (DW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_trans_id_i (req_tid),
    .req_data_i     (req_data),
    .req_ex_i       (req_ex),
    .wb_valid_o     (wb_valid),
    .wb_ready_i     (wb_ready),
    .wb_trans_id_o  (wb_tid),
    .wb_data_o      (wb_data),
    .wb_ex_o        (wb_ex),
    .conflict_cnt_o (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [TW-1:0] tid, input logic [DW-1:0] d, input logic exv);
    exception_t e;
    e       = '0;
    e.valid = exv;
    e.cause = d;
    req_valid[i]          = 1'b1;
    req_tid[i*TW +: TW]   = tid;
    req_data[i*DW +: DW]  = d;
    req_ex[i*EXW +: EXW]  = e;
  endtask

  task automatic clr_reqs();
    req_valid = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; wb_ready = 1'b0;
    req_valid = '0; req_tid = '0; req_data = '0; req_ex = '0;
    step(); step();
    if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0h want 0", wb_valid); end n_vec++;
    if (wb_tid !== '0) begin n_err++; $display("FAIL rst_tid: got %0h want 0", wb_tid); end n_vec++;
    if (wb_data !== '0) begin n_err++; $display("FAIL rst_data: got %0h want 0", wb_data); end n_vec++;
    if (wb_ex !== '0) begin n_err++; $display("FAIL rst_ex: got %0h want 0", wb_ex); end n_vec++;
    if (req_ready !== 3'b111) begin n_err++; $display("FAIL rst_ready: got %b want 111", req_ready); end n_vec++;
    if (cnt !== 32'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", cnt); end n_vec++;
    rst_n = 1'b1;
  endtask

  task automatic test_all_three();
    wb_ready = 1'b1;
    set_req(0, 3'd1, 64'h10, 1'b0);
    set_req(1, 3'd2, 64'h20, 1'b0);
    set_req(2, 3'd3, 64'h30, 1'b1);
    step(); clr_reqs();
    if (wb_valid !== 1'b1 || wb_tid !== 3'd1) begin n_err++; $display("FAIL all3_g0: got v=%0h tid=%0d want v=1 tid=1", wb_valid, wb_tid); end n_vec++;
    if (req_ready !== 3'b001) begin n_err++; $display("FAIL all3_ready: got %b want 001", req_ready); end n_vec++;
    if (wb_ex.valid !== 1'b0) begin n_err++; $display("FAIL all3_ex0: got %0h want 0", wb_ex.valid); end n_vec++;
    step();
    if (wb_valid !== 1'b1 || wb_tid !== 3'd2) begin n_err++; $display("FAIL all3_g1: got v=%0h tid=%0d want v=1 tid=2", wb_valid, wb_tid); end n_vec++;
    step();
    if (wb_valid !== 1'b1 || wb_tid !== 3'd3 || wb_data !== 64'h30) begin n_err++; $display("FAIL all3_g2: got v=%0h tid=%0d data=%0h want v=1 tid=3 data=30", wb_valid, wb_tid, wb_data); end n_vec++;
    if (wb_ex.valid !== 1'b1 || wb_ex.cause !== 64'h30) begin n_err++; $display("FAIL all3_ex2: got v=%0h cause=%0h want v=1 cause=30", wb_ex.valid, wb_ex.cause); end n_vec++;
    step();
    if (wb_valid !== 1'b0) begin n_err++; $display("FAIL all3_idle: got %0h want 0", wb_valid); end n_vec++;
  endtask

  task automatic test_single();
    wb_ready = 1'b1;
    set_req(0, 3'd5, 64'hAB, 1'b0);
    step(); clr_reqs();
    if (wb_valid !== 1'b1 || wb_tid !== 3'd5 || wb_data !== 64'hAB) begin n_err++; $display("FAIL single_out: got v=%0h tid=%0d data=%0h want v=1 tid=5 data=ab", wb_valid, wb_tid, wb_data); end n_vec++;
    step();
    if (wb_valid !== 1'b0) begin n_err++; $display("FAIL single_once: got %0h want 0", wb_valid); end n_vec++;
    if (wb_tid !== 3'd5) begin n_err++; $display("FAIL single_hold: got %0d want 5", wb_tid); end n_vec++;
  endtask

  task automatic test_stall();
    wb_ready = 1'b0;
    set_req(1, 3'd6, 64'h66, 1'b0);
    step(); clr_reqs();
    for (int s = 0; s < 4; s++) begin
      if (s == 0) begin
        if (req_ready !== 3'b101) begin n_err++; $display("FAIL stall_ready: got %b want 101", req_ready); end n_vec++;
        set_req(0, 3'd4, 64'h44, 1'b0);
      end
      if (wb_valid !== 1'b1 || wb_tid !== 3'd6 || wb_data !== 64'h66) begin n_err++; $display("FAIL stall_hold%0d: got v=%0h tid=%0d want v=1 tid=6", s, wb_valid, wb_tid); end n_vec++;
      if (s < 3) begin
        step(); clr_reqs();
      end
    end
    wb_ready = 1'b1;
    step();
    if (wb_valid !== 1'b1 || wb_tid !== 3'd4) begin n_err++; $display("FAIL stall_next: got v=%0h tid=%0d want v=1 tid=4", wb_valid, wb_tid); end n_vec++;
    step();
    if (wb_valid !== 1'b0) begin n_err++; $display("FAIL stall_idle: got %0h want 0", wb_valid); end n_vec++;
    if (cnt !== (PERF ? 32'd5 : 32'd0)) begin n_err++; $display("FAIL stall_cnt: got %0d want %0d", cnt, PERF ? 5 : 0); end n_vec++;
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_req(0, 3'(k), 64'h100 + 64'(k), 1'b0);
      if (k > 0) begin
        if (wb_valid !== 1'b1 || wb_tid !== 3'(k - 1) || wb_data !== 64'h100 + 64'(k - 1)) begin n_err++; $display("FAIL b2b_wb%0d: got v=%0h tid=%0d data=%0h want tid=%0d", k, wb_valid, wb_tid, wb_data, k - 1); end n_vec++;
      end
      if (req_ready[0] !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d: got %0h want 1", k, req_ready[0]); end n_vec++;
      step();
    end
    clr_reqs();
    if (wb_valid !== 1'b1 || wb_tid !== 3'd5) begin n_err++; $display("FAIL b2b_last: got v=%0h tid=%0d want v=1 tid=5", wb_valid, wb_tid); end n_vec++;
    step();
    if (wb_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %0h want 0", wb_valid); end n_vec++;
  endtask

  task automatic test_flush();
    wb_ready = 1'b0;
    set_req(0, 3'd1, 64'h11, 1'b0);
    set_req(1, 3'd2, 64'h22, 1'b0);
    set_req(2, 3'd3, 64'h33, 1'b0);
    step(); clr_reqs();
    if (req_ready !== 3'b000) begin n_err++; $display("FAIL flush_full: got %b want 000", req_ready); end n_vec++;
    flush = 1'b1;
    set_req(0, 3'd7, 64'h77, 1'b0);
    #1;
    if (req_ready !== 3'b111) begin n_err++; $display("FAIL flush_ready: got %b want 111", req_ready); end n_vec++;
    step();
    flush = 1'b0; clr_reqs();
    if (wb_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0h want 0", wb_valid); end n_vec++;
    if (req_ready !== 3'b111) begin n_err++; $display("FAIL flush_after: got %b want 111", req_ready); end n_vec++;
    wb_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (wb_valid !== 1'b0) begin n_err++; $display("FAIL flush_stale%0d: got %0h want 0", c, wb_valid); end n_vec++;
    end
    if (cnt !== (PERF ? 32'd6 : 32'd0)) begin n_err++; $display("FAIL flush_cnt: got %0d want %0d", cnt, PERF ? 6 : 0); end n_vec++;
  endtask

  task automatic test_reset_mid_stall();
    wb_ready = 1'b0;
    set_req(2, 3'd3, 64'h3C, 1'b0);
    step(); clr_reqs();
    if (wb_valid !== 1'b1 || wb_tid !== 3'd3) begin n_err++; $display("FAIL rstm_pre: got v=%0h tid=%0d want v=1 tid=3", wb_valid, wb_tid); end n_vec++;
    #2 rst_n = 1'b0;
    #1;
    if (wb_valid !== 1'b0 || wb_tid !== '0) begin n_err++; $display("FAIL rstm_out: got v=%0h tid=%0d want v=0 tid=0", wb_valid, wb_tid); end n_vec++;
    if (req_ready !== 3'b111) begin n_err++; $display("FAIL rstm_ready: got %b want 111", req_ready); end n_vec++;
    if (cnt !== 32'd0) begin n_err++; $display("FAIL rstm_cnt: got %0d want 0", cnt); end n_vec++;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    wb_ready = 1'b0;
    set_req(1, 3'd6, 64'h66, 1'b0);
    step(); clr_reqs();
    if (wb_tid !== 3'd6) begin n_err++; $display("FAIL lock_first: got %0d want 6", wb_tid); end n_vec++;
    set_req(0, 3'd4, 64'h44, 1'b0);
    step(); clr_reqs();
    if (wb_valid !== 1'b1 || wb_tid !== 3'd6) begin n_err++; $display("FAIL lock_held: got v=%0h tid=%0d want v=1 tid=6", wb_valid, wb_tid); end n_vec++;
    wb_ready = 1'b1;
    step();
    if (wb_valid !== 1'b1 || wb_tid !== 3'd4 || wb_data !== 64'h44) begin n_err++; $display("FAIL lock_next: got v=%0h tid=%0d data=%0h want v=1 tid=4 data=44", wb_valid, wb_tid, wb_data); end n_vec++;
    step();
    if (wb_valid !== 1'b0) begin n_err++; $display("FAIL lock_idle: got %0h want 0", wb_valid); end n_vec++;
    if (cnt !== (PERF ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL lock_cnt: got %0d want %0d", cnt, PERF ? 1 : 0); end n_vec++;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_all_three();
    test_single();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    test_lock();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
